// File: rtl/vga_timing_pattern_gen.sv
// Parametrised VGA raster engine: HS/VS/DE timing plus a selectable RGB source
// (black, colour bars, checkerboard, external pixel), all behind one output register.
module vga_timing_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter bit HS_POL     = 1'b0,
  parameter bit VS_POL     = 1'b0,
  parameter int COLOR_W    = 4,
  parameter int CHECK_LOG2 = 5,
  parameter int FRAME_W    = 16,
  localparam int H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int HW        = $clog2(H_TOTAL),
  localparam int VW        = $clog2(V_TOTAL)
) (
  input  logic                 iVGA_CLK,
  input  logic                 iRST,
  input  logic [1:0]           iMode,
  input  logic [3*COLOR_W-1:0] iPix,
  output logic [HW-1:0]        oX,
  output logic [VW-1:0]        oY,
  output logic                 oReq,
  output logic [COLOR_W-1:0]   r_data,
  output logic [COLOR_W-1:0]   g_data,
  output logic [COLOR_W-1:0]   b_data,
  output logic                 oHS,
  output logic                 oVS,
  output logic                 oDE,
  output logic                 oFrameStart,
  output logic [FRAME_W-1:0]   oFrame
);

  if (H_FP < 1 || H_SYNC < 1 || H_BP < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1 || COLOR_W < 1)
  begin : g_bad_params
    $error("vga_timing_pattern_gen: porch/sync widths and COLOR_W must all be >= 1");
  end

  typedef enum logic [1:0] {SRC_BLACK, SRC_BARS, SRC_CHECK, SRC_EXT} src_e;

  logic [HW-1:0]      r_h;
  logic [VW-1:0]      r_v;
  src_e               r_mode;
  logic               r_started;
  logic [COLOR_W-1:0] r_red, r_grn, r_blu;
  logic               r_hs, r_vs, r_de, r_fs;
  logic [FRAME_W-1:0] r_frame;

  logic               w_origin, w_req, w_hs_act, w_vs_act, w_chk;
  src_e               w_mode;
  logic [2:0]         w_bar;
  logic [COLOR_W-1:0] w_red, w_grn, w_blu;

  assign w_origin = (r_h == '0) && (r_v == '0);
  // The pixel at (0,0) already uses the newly sampled mode, so a switch lands on a frame boundary.
  assign w_mode   = w_origin ? src_e'(iMode) : r_mode;
  assign w_req    = (int'(r_h) < H_ACTIVE) && (int'(r_v) < V_ACTIVE);
  assign w_hs_act = (int'(r_h) >= H_ACTIVE + H_FP) && (int'(r_h) < H_ACTIVE + H_FP + H_SYNC);
  assign w_vs_act = (int'(r_v) >= V_ACTIVE + V_FP) && (int'(r_v) < V_ACTIVE + V_FP + V_SYNC);
  assign w_chk    = (((32'(r_h) >> CHECK_LOG2) ^ (32'(r_v) >> CHECK_LOG2)) & 32'd1) != 32'd0;

  // bar = floor(h*8/H_ACTIVE): bar >= k exactly when h >= ceil(k*H_ACTIVE/8), all constants.
  always_comb begin
    w_bar = '0;
    for (int unsigned k = 1; k < 8; k++) begin
      if (int'(r_h) >= int'((k * unsigned'(H_ACTIVE) + 7) / 8)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_red = '0;
    w_grn = '0;
    w_blu = '0;
    if (w_req) begin
      unique case (w_mode)
        SRC_BARS: begin
          w_red = {COLOR_W{~w_bar[1]}};
          w_grn = {COLOR_W{~w_bar[2]}};
          w_blu = {COLOR_W{~w_bar[0]}};
        end
        SRC_CHECK: begin
          w_red = {COLOR_W{w_chk}};
          w_grn = {COLOR_W{w_chk}};
          w_blu = {COLOR_W{w_chk}};
        end
        SRC_EXT: begin
          w_red = iPix[3*COLOR_W-1:2*COLOR_W];
          w_grn = iPix[2*COLOR_W-1:COLOR_W];
          w_blu = iPix[COLOR_W-1:0];
        end
        SRC_BLACK: ;
      endcase
    end
  end

  always_ff @(posedge iVGA_CLK) begin
    if (iRST) begin
      r_h       <= '0;
      r_v       <= '0;
      r_mode    <= SRC_BLACK;
      r_started <= 1'b0;
      r_red     <= '0;
      r_grn     <= '0;
      r_blu     <= '0;
      r_hs      <= ~HS_POL;
      r_vs      <= ~VS_POL;
      r_de      <= 1'b0;
      r_fs      <= 1'b0;
      r_frame   <= '0;
    end else begin
      if (int'(r_h) == H_TOTAL - 1) begin
        r_h <= '0;
        if (int'(r_v) == V_TOTAL - 1) r_v <= '0;
        else                          r_v <= r_v + VW'(1);
      end else begin
        r_h <= r_h + HW'(1);
      end
      r_mode <= w_mode;
      r_red  <= w_red;
      r_grn  <= w_grn;
      r_blu  <= w_blu;
      r_hs   <= w_hs_act ? HS_POL : ~HS_POL;
      r_vs   <= w_vs_act ? VS_POL : ~VS_POL;
      r_de   <= w_req;
      r_fs   <= w_origin;
      // Count completed frames: the very first frame start after reset is not a completion.
      if (w_origin) begin
        r_started <= 1'b1;
        if (r_started) r_frame <= r_frame + FRAME_W'(1);
      end
    end
  end

  assign oX          = r_h;
  assign oY          = r_v;
  assign oReq        = w_req;
  assign r_data      = r_red;
  assign g_data      = r_grn;
  assign b_data      = r_blu;
  assign oHS         = r_hs;
  assign oVS         = r_vs;
  assign oDE         = r_de;
  assign oFrameStart = r_fs;
  assign oFrame      = r_frame;

endmodule

// File: tb/tb_vga_timing_pattern_gen.sv
// Bench for vga_timing_pattern_gen on a shrunken raster (28x18) with both sync polarities;
// a cycle-index model checks every output each cycle, directed points pin the model.
module tb_vga_timing_pattern_gen;
  localparam int HA = 20, HF = 2, HSY = 3, HB = 3;
  localparam int VA = 12, VF = 2, VSY = 2, VB = 2;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VT = VA + VF + VSY + VB;
  localparam int CL = 2;

  logic        clk = 1'b0;
  logic        iRST = 1'b1;
  logic [1:0]  iMode = 2'd0;
  logic [11:0] iPix, iPix2;
  logic [4:0]  oX, oY, oX2, oY2;
  logic        oReq, oHS, oVS, oDE, oFS, oReq2, oHS2, oVS2, oDE2, oFS2;
  logic [3:0]  r_data, g_data, b_data, r2, g2, b2;
  logic [15:0] oFrame, oFrame2;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  assign iPix  = {oX[3:0], oY[3:0], 4'hA};
  assign iPix2 = {oX2[3:0], oY2[3:0], 4'hA};

  vga_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOR_W(4), .CHECK_LOG2(CL), .FRAME_W(16)
  ) dut (
    .iVGA_CLK(clk), .iRST(iRST), .iMode(iMode), .iPix(iPix), .oX(oX), .oY(oY), .oReq(oReq),
    .r_data(r_data), .g_data(g_data), .b_data(b_data), .oHS(oHS), .oVS(oVS), .oDE(oDE),
    .oFrameStart(oFS), .oFrame(oFrame)
  );

  vga_timing_pattern_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOR_W(4), .CHECK_LOG2(CL), .FRAME_W(16)
  ) dut_pol1 (
    .iVGA_CLK(clk), .iRST(iRST), .iMode(iMode), .iPix(iPix2), .oX(oX2), .oY(oY2), .oReq(oReq2),
    .r_data(r2), .g_data(g2), .b_data(b2), .oHS(oHS2), .oVS(oVS2), .oDE(oDE2),
    .oFrameStart(oFS2), .oFrame(oFrame2)
  );

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [11:0] exp_pix(input int mode, input int x, input int y);
    int bar;
    logic [3:0] xs, ys;
    if (!(x < HA && y < VA)) return 12'h000;
    case (mode)
      1: begin
        bar = (x * 8) / HA;
        return {((bar == 0 || bar == 1 || bar == 4 || bar == 5) ? 4'hF : 4'h0),
                ((bar < 4) ? 4'hF : 4'h0),
                ((bar % 2 == 0) ? 4'hF : 4'h0)};
      end
      2: return ((((x >> CL) ^ (y >> CL)) & 1) != 0) ? 12'hFFF : 12'h000;
      3: begin
        xs = 4'(x);
        ys = 4'(y);
        return {xs, ys, 4'hA};
      end
      default: return 12'h000;
    endcase
  endfunction

  // Model: counters follow from the cycle index since reset; registered outputs lag one cycle.
  int n = 0;
  bit valid = 1'b0;
  int m_mode = 0;
  bit m_started = 1'b0;
  logic [11:0] e_rgb = '0;
  bit e_hs = 1'b0, e_vs = 1'b0, e_de = 1'b0, e_fs = 1'b0;
  int e_frame = 0;

  always @(negedge clk) begin : model
    int x, y;
    x = n % HT;
    y = (n / HT) % VT;
    if (valid) begin
      chk("oX", int'(oX), x);
      chk("oY", int'(oY), y);
      chk("oReq", int'(oReq), (x < HA && y < VA) ? 1 : 0);
      chk("rgb", int'({r_data, g_data, b_data}), int'(e_rgb));
      chk("oHS", int'(oHS), e_hs ? 0 : 1);
      chk("oVS", int'(oVS), e_vs ? 0 : 1);
      chk("oDE", int'(oDE), int'(e_de));
      chk("oFrameStart", int'(oFS), int'(e_fs));
      chk("oFrame", int'(oFrame), e_frame % 65536);
      chk("pol1_xy", int'({oX2, oY2}), int'({5'(x), 5'(y)}));
      chk("pol1_req", int'(oReq2), (x < HA && y < VA) ? 1 : 0);
      chk("pol1_rgb", int'({r2, g2, b2}), int'(e_rgb));
      chk("pol1_oHS", int'(oHS2), e_hs ? 1 : 0);
      chk("pol1_oVS", int'(oVS2), e_vs ? 1 : 0);
      chk("pol1_de_fs", int'({oDE2, oFS2}), int'({e_de, e_fs}));
      chk("pol1_oFrame", int'(oFrame2), e_frame % 65536);
    end
    if (iRST) begin
      n = 0; valid = 1'b1; m_mode = 0; m_started = 1'b0;
      e_rgb = '0; e_hs = 1'b0; e_vs = 1'b0; e_de = 1'b0; e_fs = 1'b0; e_frame = 0;
    end else if (valid) begin
      if (x == 0 && y == 0) m_mode = int'(iMode);
      e_rgb = exp_pix(m_mode, x, y);
      e_hs  = (x >= HA + HF) && (x < HA + HF + HSY);
      e_vs  = (y >= VA + VF) && (y < VA + VF + VSY);
      e_de  = (x < HA) && (y < VA);
      e_fs  = (x == 0) && (y == 0);
      if (e_fs) begin
        if (m_started) e_frame++;
        m_started = 1'b1;
      end
      n++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int x, input int y);
    int cnt;
    cnt = 0;
    while (!(int'(oX) == x && int'(oY) == y) && cnt < 2000) begin
      tick();
      cnt++;
    end
    if (cnt >= 2000) begin
      n_chk++;
      $display("FAIL wait_pos: never reached x=%0d y=%0d, stuck at x=%0d y=%0d", x, y, oX, oY);
    end
  endtask

  int          bx[10] = '{0, 2, 3, 5, 8, 10, 13, 15, 17, 18};
  logic [11:0] bv[10] = '{12'hFFF, 12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                          12'hF0F, 12'hF00, 12'h00F, 12'h00F, 12'h000};

  initial begin
    repeat (3) tick();
    chk("rst_oX", int'(oX), 0);
    chk("rst_oY", int'(oY), 0);
    chk("rst_oHS", int'(oHS), 1);
    chk("rst_oVS", int'(oVS), 1);
    chk("rst_pol1_oHS", int'(oHS2), 0);
    chk("rst_pol1_oVS", int'(oVS2), 0);
    chk("rst_rgb_de_fs", int'({r_data, g_data, b_data, oDE, oFS}), 0);
    chk("rst_oFrame", int'(oFrame), 0);
    iRST = 1'b0;

    // Sync edges on line 0 of frame 0, registered one cycle behind the counters.
    wait_pos(21, 0);
    tick(); chk("hs_x21", int'(oHS), 1);
    tick(); chk("hs_x22", int'(oHS), 0); chk("hs_x22_pol1", int'(oHS2), 1);
    repeat (3) tick(); chk("hs_x25", int'(oHS), 1);
    wait_pos(19, 11);
    tick(); chk("de_x19_y11", int'(oDE), 1);
    tick(); chk("de_x20_y11", int'(oDE), 0);
    wait_pos(0, 13); tick(); chk("vs_y13", int'(oVS), 1);
    wait_pos(0, 14); tick(); chk("vs_y14", int'(oVS), 0);

    // Frames 0 and 1 black; bars requested mid frame 1 appear at frame 2.
    wait_pos(5, 0);
    iMode = 2'd1;
    wait_pos(3, 8); tick(); chk("still_black", int'({r_data, g_data, b_data}), 0);
    wait_pos(0, 0);
    for (int i = 0; i < 10; i++) begin
      wait_pos(bx[i], 0);
      tick();
      chk($sformatf("bar_x%0d", bx[i]), int'({r_data, g_data, b_data}), int'(bv[i]));
    end
    wait_pos(24, 0); tick(); chk("bar_blank", int'({r_data, g_data, b_data, oDE}), 0);

    wait_pos(0, 5);
    iMode = 2'd2;
    wait_pos(3, 8); tick(); chk("bars_hold", int'({r_data, g_data, b_data}), 12'hFF0);
    wait_pos(0, 0); tick();
    chk("fs_frame3", int'(oFS), 1);
    chk("oFrame_3", int'(oFrame), 3);
    chk("chk_0_0", int'({r_data, g_data, b_data}), 0);
    wait_pos(4, 0); tick(); chk("chk_4_0", int'({r_data, g_data, b_data}), 12'hFFF);
    wait_pos(0, 4); tick(); chk("chk_0_4", int'({r_data, g_data, b_data}), 12'hFFF);
    wait_pos(4, 4); tick(); chk("chk_4_4", int'({r_data, g_data, b_data}), 0);

    wait_pos(5, 5);
    iMode = 2'd3;
    wait_pos(0, 0);
    wait_pos(5, 3); tick();
    chk("ext_5_3", int'({r_data, g_data, b_data}), 12'h53A);
    chk("ext_de", int'(oDE), 1);

    wait_pos(10, 5);
    iRST = 1'b1;
    tick();
    iRST = 1'b0;
    chk("mid_rst_xy", int'({oX, oY}), 0);
    chk("mid_rst_oFrame", int'(oFrame), 0);
    chk("mid_rst_out", int'({r_data, g_data, b_data, oDE, oFS}), 0);
    chk("mid_rst_sync", int'({oHS, oVS, oHS2, oVS2}), 4'b1100);

    repeat (HT * VT + 40) tick();
    chk("oFrame_after_rst", int'(oFrame), 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/vga_timing_pattern_gen.md
Name: vga_timing_pattern_gen

Overview:
Parametrised VGA raster engine that supersedes the fixed 640x480 timing inside the current VGA controller. It generates HS/VS/DE from generic porch and sync parameters with selectable sync polarity and colour depth. It also drives RGB from one of four sources: black, colour bars, checkerboard, or an external pixel source addressed by oX/oY. It sits between the VGA PLL clock and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (clocks)
H_SYNC, 96, horizontal sync width
H_BP, 48, horizontal back porch
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width
V_BP, 33, vertical back porch
HS_POL, 0, asserted level of oHS (0 = active-low)
VS_POL, 0, asserted level of oVS
COLOR_W, 4, bits per colour channel
CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels
FRAME_W, 16, frame counter width

Ports:
iVGA_CLK  in  1  pixel clock; all logic on rising edge
iRST  in  1  synchronous, active-high reset
iMode  in  2  source select: 0 black, 1 bars, 2 checker, 3 external
iPix  in  3*COLOR_W  external pixel {R,G,B}, combinational function of oX/oY
oX  out  clog2(H_TOTAL)  current horizontal counter (unregistered view of h_cnt)
oY  out  clog2(V_TOTAL)  current vertical counter
oReq  out  1  h_cnt<H_ACTIVE && v_cnt<V_ACTIVE (current cycle)
r_data  out  COLOR_W  red
g_data  out  COLOR_W  green
b_data  out  COLOR_W  blue
oHS  out  1  horizontal sync
oVS  out  1  vertical sync
oDE  out  1  registered data-enable
oFrameStart  out  1  one-cycle pulse, registered, coincident with pixel (0,0)
oFrame  out  FRAME_W  completed-frame count

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- h_cnt increments every clock; at H_TOTAL-1 it wraps to 0 and v_cnt increments; v_cnt wraps from V_TOTAL-1 to 0.
- Comparisons on counters: hs_act when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vs_act uses the same rule on v_cnt with vertical params.
- Output stage is one register: r/g/b, oHS, oVS, oDE and oFrameStart at cycle t+1 reflect counters and iPix at cycle t. oX/oY/oReq have zero latency.
- oHS = hs_act ? HS_POL : ~HS_POL; oVS likewise. oDE = registered oReq.
- RGB is forced to 0 whenever oReq=0 at the source cycle, regardless of mode.
- Mode register: iMode is sampled only on the cycle where h_cnt=0 and v_cnt=0. A mid-frame change takes effect at the next frame, so no tearing.
- Bars: bar = floor(h_cnt*8/H_ACTIVE), computed from localparam thresholds with no runtime divider. Channel value is all-ones or zero:
  - R for bars {0,1,4,5}
  - G for bars {0,1,2,3}
  - B for bars {0,2,4,6}
  - Order: white, yellow, cyan, green, magenta, red, blue, black.
- Checker: white if ((h_cnt>>CHECK_LOG2) ^ (v_cnt>>CHECK_LOG2)) & 1, else black.
- External: iPix is registered unmodified; R = iPix[3*COLOR_W-1:2*COLOR_W], B = LSBs.
- oFrame increments on the same edge that oFrameStart is registered high, except on the first frame after reset. It wraps modulo 2^FRAME_W.
- Reset: h_cnt=0, v_cnt=0, mode=0, r/g/b=0, oDE=0, oHS=~HS_POL, oVS=~VS_POL, oFrameStart=0, oFrame=0. The first cycle after iRST deasserts is pixel (0,0).
- Reset asserted mid-line or mid-frame overrides everything that cycle and restarts from the reset state.
- Parameter legality is checked at elaboration: all porch/sync values >=1 and COLOR_W >=1; otherwise $error.

Test Plan:
- Defaults, mode 0, run 2 frames -> HS period 800 clocks, low for 96 clocks starting at h=656 (+1 latency); VS low for lines 490-491; oDE high for 640x480 per frame; RGB always 0.
- Mode 1 -> on line 0, registered RGB changes every 80 pixels, sequence F/F/F, F/F/0, 0/F/F, 0/F/0, F/0/F, F/0/0, 0/0/F, 0/0/0; RGB=0 during blanking.
- Mode 2 with CHECK_LOG2=5 -> pixel (0,0) black, (32,0) white, (32,32) black, (0,32) white.
- Mode 3, iPix = {oX[3:0],oY[3:0],4'hA} -> pixel at x=5, y=3 outputs R=5, G=3, B=A one clock later, aligned with oDE.
- Switch iMode 1->2 at line 100 -> output stays bars to end of frame; checker starts at next (0,0); oFrameStart pulses there and oFrame increments.
- Assert iRST at h=300, v=200 for 1 cycle -> next cycle oX=0, oY=0; outputs return to reset values; oFrame=0. HS_POL=1 instance -> idle oHS=0, pulse high.
